// File: rtl/gmii_rate_adapter_if.sv
// Byte-stream and PHY-side signal bundle for gmii_rate_adapter.
// slave = adapter view, master = upstream MAC / PHY model view.
interface gmii_rate_adapter_if;
    logic [7:0] tx_dat;
    logic       tx_val;
    logic       tx_err;
    logic       tx_rdy;
    logic [7:0] phy_tx_dat;
    logic       phy_tx_val;
    logic       phy_tx_err;
    logic [7:0] phy_rx_dat;
    logic       phy_rx_val;
    logic       phy_rx_err;
    logic       phy_rx_ce;
    logic [7:0] rx_dat;
    logic       rx_val;
    logic       rx_err;

    modport slave (
        input  tx_dat, tx_val, tx_err,
        output tx_rdy,
        output phy_tx_dat, phy_tx_val, phy_tx_err,
        input  phy_rx_dat, phy_rx_val, phy_rx_err, phy_rx_ce,
        output rx_dat, rx_val, rx_err
    );

    modport master (
        output tx_dat, tx_val, tx_err,
        input  tx_rdy,
        input  phy_tx_dat, phy_tx_val, phy_tx_err,
        output phy_rx_dat, phy_rx_val, phy_rx_err, phy_rx_ce,
        input  rx_dat, rx_val, rx_err
    );
endinterface

// File: rtl/gmii_rate_adapter.sv
// GMII 10/100/1000 rate adapter: byte <-> nibble conversion on a single 125 MHz clock.
// Optional in-band PHY status decode is enabled by defining RGMII_INBAND_STATUS_EN.
module gmii_rate_adapter #(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cfg_speed,
    gmii_rate_adapter_if.slave bus,
    output logic               stat_link,
    output logic [1:0]         stat_speed,
    output logic               stat_duplex
);
    localparam int            CW       = $clog2(DIV_10 + 1);
    localparam logic [CW-1:0] LAST_100 = CW'(DIV_100 - 1);
    localparam logic [CW-1:0] LAST_10  = CW'(DIV_10 - 1);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LO   = 2'd1,
        TX_HI   = 2'd2
    } tx_state_e;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_last;
    logic [1:0]    spd_q, spd_d, spd_src;
    logic          gig;
    logic [7:0]    byte_q, byte_d;
    logic          berr_q, berr_d;
    logic [7:0]    gdat_q, gdat_d;
    logic          gval_q, gval_d, gerr_q, gerr_d;
    logic          up_q, up_d;

    logic [3:0]    nib_q, nib_d;
    logic          nerr_q, nerr_d;
    logic          ph_q, ph_d;
    logic          pval_q, pval_d;
    logic [7:0]    rx_dat_q, rx_dat_d;
    logic          rx_val_q, rx_val_d;
    logic          rx_err_q, rx_err_d;

    // 10 = 1000M and 11 is treated the same, so bit 1 alone selects gigabit.
    assign gig      = spd_q[1];
    assign cnt_last = spd_q[0] ? LAST_100 : LAST_10;
    assign up_d     = 1'b1;

    // NOTE: every variable gets a default before the case, so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        spd_d          = spd_q;
        byte_d         = byte_q;
        berr_d         = berr_q;
        gdat_d         = '0;
        gval_d         = 1'b0;
        gerr_d         = 1'b0;
        bus.tx_rdy     = 1'b0;
        bus.phy_tx_dat = gdat_q;
        bus.phy_tx_val = gval_q;
        bus.phy_tx_err = gerr_q;
        case (state_q)
            TX_IDLE: begin
                bus.tx_rdy = up_q;
                if (gig) begin
                    gdat_d = bus.tx_dat;
                    gval_d = bus.tx_val && up_q;
                    gerr_d = bus.tx_err;
                    spd_d  = spd_src;
                end else if (bus.tx_val && up_q) begin
                    state_d = TX_LO;
                    cnt_d   = '0;
                    byte_d  = bus.tx_dat;
                    berr_d  = bus.tx_err;
                end else begin
                    spd_d = spd_src;
                end
            end
            TX_LO: begin
                bus.phy_tx_dat = {byte_q[3:0], byte_q[3:0]};
                bus.phy_tx_val = 1'b1;
                bus.phy_tx_err = berr_q;
                if (cnt_q == cnt_last) begin
                    state_d = TX_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_HI: begin
                bus.phy_tx_dat = {byte_q[7:4], byte_q[7:4]};
                bus.phy_tx_val = 1'b1;
                bus.phy_tx_err = berr_q;
                if (cnt_q == cnt_last) begin
                    // Last hold cycle doubles as the accept slot for back-to-back bytes.
                    bus.tx_rdy = up_q;
                    cnt_d      = '0;
                    if (bus.tx_val && up_q) begin
                        state_d = TX_LO;
                        byte_d  = bus.tx_dat;
                        berr_d  = bus.tx_err;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        nib_d    = nib_q;
        nerr_d   = nerr_q;
        ph_d     = ph_q;
        pval_d   = pval_q;
        rx_dat_d = rx_dat_q;
        rx_err_d = rx_err_q;
        rx_val_d = 1'b0;
        if (bus.phy_rx_ce) begin
            pval_d = bus.phy_rx_val;
            if (gig) begin
                rx_dat_d = bus.phy_rx_dat;
                rx_err_d = bus.phy_rx_err;
                rx_val_d = bus.phy_rx_val;
                ph_d     = 1'b0;
            end else if (bus.phy_rx_val) begin
                // A rising phy_rx_val always restarts at the low nibble.
                if (ph_q && pval_q) begin
                    rx_dat_d = {bus.phy_rx_dat[3:0], nib_q};
                    rx_err_d = nerr_q | bus.phy_rx_err;
                    rx_val_d = 1'b1;
                    ph_d     = 1'b0;
                end else begin
                    nib_d  = bus.phy_rx_dat[3:0];
                    nerr_d = bus.phy_rx_err;
                    ph_d   = 1'b1;
                end
            end else begin
                if (ph_q) begin
                    rx_dat_d = {4'h0, nib_q};
                    rx_err_d = 1'b1;
                    rx_val_d = 1'b1;
                end
                ph_d = 1'b0;
            end
        end
    end

    assign bus.rx_dat = rx_dat_q;
    assign bus.rx_val = rx_val_q;
    assign bus.rx_err = rx_err_q;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            spd_q    <= cfg_speed;
            byte_q   <= '0;
            berr_q   <= 1'b0;
            gdat_q   <= '0;
            gval_q   <= 1'b0;
            gerr_q   <= 1'b0;
            up_q     <= 1'b0;
            nib_q    <= '0;
            nerr_q   <= 1'b0;
            ph_q     <= 1'b0;
            pval_q   <= 1'b0;
            rx_dat_q <= '0;
            rx_val_q <= 1'b0;
            rx_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            spd_q    <= spd_d;
            byte_q   <= byte_d;
            berr_q   <= berr_d;
            gdat_q   <= gdat_d;
            gval_q   <= gval_d;
            gerr_q   <= gerr_d;
            up_q     <= up_d;
            nib_q    <= nib_d;
            nerr_q   <= nerr_d;
            ph_q     <= ph_d;
            pval_q   <= pval_d;
            rx_dat_q <= rx_dat_d;
            rx_val_q <= rx_val_d;
            rx_err_q <= rx_err_d;
        end
    end

`ifdef RGMII_INBAND_STATUS_EN
    logic [3:0] cand_q, cand_d;
    logic       cand_vld_q, cand_vld_d;
    logic       link_q, link_d;
    logic [1:0] sspd_q, sspd_d;
    logic       dup_q, dup_d;

    // Status is only trusted after two identical consecutive idle decodes.
    always_comb begin
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        link_d     = link_q;
        sspd_d     = sspd_q;
        dup_d      = dup_q;
        if (bus.phy_rx_ce && !bus.phy_rx_val && !bus.phy_rx_err) begin
            cand_d     = bus.phy_rx_dat[3:0];
            cand_vld_d = 1'b1;
            if (cand_vld_q && (cand_q == bus.phy_rx_dat[3:0])) begin
                link_d = bus.phy_rx_dat[0];
                sspd_d = bus.phy_rx_dat[2:1];
                dup_d  = bus.phy_rx_dat[3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            link_q     <= 1'b0;
            sspd_q     <= cfg_speed;
            dup_q      <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            link_q     <= link_d;
            sspd_q     <= sspd_d;
            dup_q      <= dup_d;
        end
    end

    assign spd_src     = sspd_q;
    assign stat_link   = link_q;
    assign stat_speed  = sspd_q;
    assign stat_duplex = dup_q;
`else
    assign spd_src     = cfg_speed;
    assign stat_link   = up_q;
    assign stat_speed  = cfg_speed;
    assign stat_duplex = up_q;
`endif
endmodule

// File: tb/tb_gmii_rate_adapter.sv
// Self-checking bench for gmii_rate_adapter: a frame-level reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_gmii_rate_adapter;
  localparam int D100 = 5;
  localparam int D10  = 50;

  typedef struct packed {
    logic       val;
    logic       err;
    logic [7:0] dat;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cfg_speed = 2'b10;
  logic       stat_link;
  logic [1:0] stat_speed;
  logic       stat_duplex;

  int errors = 0;
  int checks = 0;

  gmii_rate_adapter_if bus ();

  gmii_rate_adapter #(.DIV_100(D100), .DIV_10(D10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_speed  (cfg_speed),
    .bus        (bus),
    .stat_link  (stat_link),
    .stat_speed (stat_speed),
    .stat_duplex(stat_duplex)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected TX beats as a queue, nibble list per RX frame.
  beat_t      nq[$];
  beat_t      greg = '0;
  logic [1:0] mspd = 2'b10;
  logic       mup = 1'b0;
  logic       live = 1'b0;
  logic [4:0] fq[$];
  logic       mpval = 1'b0;
  beat_t      rx_exp = '0;
  beat_t      got_rx[$];

  always @(negedge clk) begin : cmp
    beat_t exp_tx;
    logic  exp_rdy, gig, idle, acc;
    int    d;
    exp_tx  = (nq.size() != 0) ? nq[0] : greg;
    exp_rdy = mup && (mspd[1] || nq.size() <= 1);
    if (live) begin
      check("tx_rdy", bus.tx_rdy, exp_rdy);
      check("phy_tx", {bus.phy_tx_val, bus.phy_tx_err, bus.phy_tx_dat}, exp_tx);
      check("rx_val", bus.rx_val, rx_exp.val);
      if (rx_exp.val) check("rx_byte", {bus.rx_err, bus.rx_dat}, {rx_exp.err, rx_exp.dat});
      if (bus.rx_val) got_rx.push_back({bus.rx_val, bus.rx_err, bus.rx_dat});
`ifndef RGMII_INBAND_STATUS_EN
      check("stat_link", stat_link, mup);
      check("stat_duplex", stat_duplex, mup);
      check("stat_speed", stat_speed, cfg_speed);
`endif
    end
    if (!rst_n) begin
      nq.delete();
      fq.delete();
      greg   = '0;
      mup    = 1'b0;
      mspd   = cfg_speed;
      mpval  = 1'b0;
      rx_exp = '0;
      live   = 1'b1;
    end else if (live) begin
      gig  = mspd[1];
      idle = (nq.size() == 0);
      acc  = bus.tx_val && exp_rdy;
      if (nq.size() != 0) void'(nq.pop_front());
      greg = gig ? beat_t'({bus.tx_val && mup, bus.tx_err, bus.tx_dat}) : beat_t'('0);
      if (acc && !gig) begin
        d = mspd[0] ? D100 : D10;
        repeat (d) nq.push_back({1'b1, bus.tx_err, bus.tx_dat[3:0], bus.tx_dat[3:0]});
        repeat (d) nq.push_back({1'b1, bus.tx_err, bus.tx_dat[7:4], bus.tx_dat[7:4]});
      end
      if (idle && !(acc && !gig)) mspd = cfg_speed;
      mup    = 1'b1;
      rx_exp = '0;
      if (bus.phy_rx_ce) begin
        if (gig) begin
          rx_exp = {bus.phy_rx_val, bus.phy_rx_err, bus.phy_rx_dat};
          fq.delete();
        end else if (bus.phy_rx_val) begin
          if (!mpval) fq.delete();
          fq.push_back({bus.phy_rx_err, bus.phy_rx_dat[3:0]});
          if (fq.size() == 2) begin
            rx_exp = {1'b1, fq[0][4] | fq[1][4], fq[1][3:0], fq[0][3:0]};
            fq.delete();
          end
        end else begin
          if (fq.size() == 1) rx_exp = {1'b1, 1'b1, 4'h0, fq[0][3:0]};
          fq.delete();
        end
        mpval = bus.phy_rx_val;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte and returns one step after the cycle it was accepted in.
  task automatic send(input logic [7:0] b, input logic e);
    int n;
    n = 0;
    bus.tx_dat = b;
    bus.tx_err = e;
    bus.tx_val = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.tx_rdy || n > 500) break;
      n++;
    end
    check("send_tx_rdy", bus.tx_rdy, 1'b1);
    tick();
  endtask

  task automatic rx_sample(input logic v, input logic [3:0] nib, input logic e);
    repeat (4) tick();
    bus.phy_rx_ce  = 1'b1;
    bus.phy_rx_val = v;
    bus.phy_rx_dat = {4'hA, nib};
    bus.phy_rx_err = e;
    tick();
    bus.phy_rx_ce = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.tx_dat     = '0;
    bus.tx_val     = 1'b0;
    bus.tx_err     = 1'b0;
    bus.phy_rx_dat = '0;
    bus.phy_rx_val = 1'b0;
    bus.phy_rx_err = 1'b0;
    bus.phy_rx_ce  = 1'b0;
`ifdef RGMII_INBAND_STATUS_EN
    cfg_speed = 2'b00;
`endif
    repeat (2) tick();
    @(negedge clk);
    check("rst_tx_rdy", bus.tx_rdy, 1'b0);
    check("rst_phy_tx", {bus.phy_tx_val, bus.phy_tx_err, bus.phy_tx_dat}, 10'h0);
    check("rst_rx", {bus.rx_val, bus.rx_err, bus.rx_dat}, 10'h0);
    check("rst_stat", {stat_link, stat_duplex}, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef RGMII_INBAND_STATUS_EN
    bus.phy_rx_ce = 1'b1; bus.phy_rx_dat = 8'h0B;
    tick();
    bus.phy_rx_ce = 1'b0;
    @(negedge clk);
    check("ib_one_decode", {stat_link, stat_speed, stat_duplex}, 4'b0000);
    tick();
    bus.phy_rx_ce = 1'b1;
    tick();
    bus.phy_rx_ce = 1'b0;
    @(negedge clk);
    check("ib_two_decodes", {stat_link, stat_speed, stat_duplex}, 4'b1011);
    tick();
    bus.phy_rx_ce = 1'b1; bus.phy_rx_dat = 8'h00;
    tick();
    bus.phy_rx_ce = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("ib_single_zero", {stat_link, stat_speed, stat_duplex}, 4'b1011);
`else
    // 1000M back-to-back bytes
    bus.tx_dat = 8'h55; bus.tx_val = 1'b1;
    @(negedge clk);
    check("g_rdy0", bus.tx_rdy, 1'b1);
    tick();
    bus.tx_dat = 8'hD5;
    @(negedge clk);
    check("g_b0", {bus.phy_tx_val, bus.phy_tx_dat}, 9'h155);
    check("g_rdy1", bus.tx_rdy, 1'b1);
    tick();
    bus.tx_val = 1'b0;
    @(negedge clk);
    check("g_b1", {bus.phy_tx_val, bus.phy_tx_dat}, 9'h1D5);

    // 100M single byte 0xA3
    cfg_speed = 2'b01;
    repeat (3) tick();
    bus.tx_dat = 8'hA3; bus.tx_val = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.tx_val = 1'b0;
      @(negedge clk);
      check("m100_nib", {bus.phy_tx_val, bus.phy_tx_dat}, (i <= 5) ? 9'h133 : 9'h1AA);
      check("m100_rdy", bus.tx_rdy, (i == 10) ? 1'b1 : 1'b0);
    end
    tick();
    @(negedge clk);
    check("m100_idle", {bus.phy_tx_val, bus.phy_tx_dat}, 9'h000);

    // 10M, three bytes, speed change to 1000M during the second
    cfg_speed = 2'b00;
    repeat (3) tick();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    cfg_speed = 2'b10;
    send(8'h56, 1'b1);
    bus.tx_val = 1'b0;
    @(negedge clk);
    check("m10_b2_lo", {bus.phy_tx_err, bus.phy_tx_dat}, 9'h166);
    n = 1;
    forever begin
      @(negedge clk);
      if (!bus.phy_tx_val || n > 300) break;
      n++;
    end
    check("m10_b2_len", n, 2 * D10);
    tick();
    send(8'h9E, 1'b0);
    bus.tx_val = 1'b0;
    @(negedge clk);
    check("m10_next_gig", {bus.phy_tx_val, bus.phy_tx_dat}, 9'h19E);

    // 100M receive with an odd trailing nibble
    cfg_speed = 2'b01;
    repeat (3) tick();
    got_rx.delete();
    rx_sample(1'b0, 4'h0, 1'b0);
    rx_sample(1'b1, 4'h5, 1'b0);
    rx_sample(1'b1, 4'h5, 1'b0);
    rx_sample(1'b1, 4'hD, 1'b0);
    rx_sample(1'b1, 4'h5, 1'b0);
    rx_sample(1'b1, 4'h2, 1'b1);
    rx_sample(1'b1, 4'h1, 1'b0);
    rx_sample(1'b1, 4'h7, 1'b0);
    rx_sample(1'b0, 4'h0, 1'b0);
    repeat (3) tick();
    check("rx100_count", got_rx.size(), 4);
    if (got_rx.size() == 4) begin
      check("rx100_b0", got_rx[0], 10'h255);
      check("rx100_b1", got_rx[1], 10'h25D);
      check("rx100_b2", got_rx[2], 10'h312);
      check("rx100_odd", got_rx[3], 10'h307);
    end

    // 1000M receive, then ce low must freeze
    cfg_speed = 2'b10;
    repeat (2) tick();
    bus.phy_rx_ce = 1'b1; bus.phy_rx_val = 1'b1; bus.phy_rx_dat = 8'hC3; bus.phy_rx_err = 1'b0;
    tick();
    bus.phy_rx_dat = 8'h3C; bus.phy_rx_err = 1'b1;
    tick();
    bus.phy_rx_ce = 1'b0; bus.phy_rx_err = 1'b0;
    repeat (3) tick();
    bus.phy_rx_val = 1'b0;
    tick();
    check("rx1g_count", got_rx.size(), 6);
    if (got_rx.size() == 6) begin
      check("rx1g_b0", got_rx[4], 10'h2C3);
      check("rx1g_b1", got_rx[5], 10'h33C);
    end

    // Reset on the third HI hold cycle of a 100M byte
    cfg_speed = 2'b01;
    repeat (3) tick();
    bus.tx_dat = 8'h3C; bus.tx_err = 1'b1; bus.tx_val = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_val = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_hi3", {bus.phy_tx_val, bus.phy_tx_err, bus.phy_tx_dat}, 10'h333);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out", {bus.phy_tx_val, bus.phy_tx_err, bus.phy_tx_dat}, 10'h0);
    check("rst_mid_rdy", bus.tx_rdy, 1'b0);
    tick();
    @(negedge clk);
    check("rst_rel_rdy", bus.tx_rdy, 1'b1);
    check("rst_rel_val", bus.phy_tx_val, 1'b0);
    repeat (12) tick();
`endif
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gmii_rate_adapter.md
GMII_RATE_ADAPTER -- requirements
Module: gmii_rate_adapter

Interface
REQ-001 Parameter DIV_100, default 5, meaning clk cycles per nibble at 100M (125 MHz / 25 MHz); legal range 2 or more.
REQ-002 Parameter DIV_10, default 50, meaning clk cycles per nibble at 10M; legal range DIV_10 > DIV_100.
REQ-003 clk  in  1  single 125 MHz clock for the whole block.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 cfg_speed  in  2  requested speed: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = treated as 1000M.
REQ-006 tx_dat / tx_val / tx_err  in  8/1/1  upstream transmit byte stream.
REQ-007 tx_rdy  out  1  byte accepted this cycle when tx_val && tx_rdy.
REQ-008 phy_tx_dat / phy_tx_val / phy_tx_err  out  8/1/1  to the DDR output stage.
REQ-009 phy_rx_dat / phy_rx_val / phy_rx_err / phy_rx_ce  in  8/1/1/1  from the DDR input stage; phy_rx_ce qualifies each sample.
REQ-010 rx_dat / rx_val / rx_err  out  8/1/1  assembled receive bytes; rx_val is a one-cycle strobe per byte.
REQ-011 stat_link / stat_speed / stat_duplex  out  1/2/1  link status and effective speed.

Function
REQ-012 Effective speed (spd) SHALL be latched from its source only while the TX FSM is in IDLE; a speed change mid-frame SHALL take effect after the frame.
REQ-013 1000M TX: tx_rdy SHALL be 1; phy_tx_* SHALL equal tx_* registered once (latency 1).
REQ-014 10/100M TX: the FSM SHALL have states IDLE, LO and HI; D = DIV_100 or DIV_10 according to spd.
REQ-015 IDLE: tx_rdy = 1; on accept, go to LO with the hold counter at 0; phy_tx_val = 0 and phy_tx_dat = 0.
REQ-016 LO: phy_tx_dat SHALL be {byte[3:0], byte[3:0]} with phy_tx_val = 1 for D cycles, then go to HI.
REQ-017 HI: phy_tx_dat SHALL be {byte[7:4], byte[7:4]} for D cycles; tx_rdy = 1 only on the last cycle (counter == D-1); accept there goes to LO, else go to IDLE.
REQ-018 phy_tx_err SHALL equal the tx_err captured with the byte, held for both nibbles.
REQ-019 1000M RX: when phy_rx_ce = 1, rx_* SHALL equal phy_rx_* registered once; rx_val = phy_rx_val && phy_rx_ce.
REQ-020 10/100M RX: on a qualified sample with phy_rx_val = 1, take phy_rx_dat[3:0]; the first nibble is the low half and the second nibble completes the byte, emitted on the next cycle.
REQ-021 Nibble phase SHALL reset to "low" on every rising phy_rx_val, i.e. phy_rx_val = 1 after a qualified sample with phy_rx_val = 0.
REQ-022 rx_err SHALL be the OR of phy_rx_err over both nibbles of the byte.
REQ-023 A frame ending on an odd nibble SHALL emit {4'h0, nibble} with rx_err = 1.
REQ-024 phy_rx_ce = 0 SHALL freeze RX state.

Reset
REQ-025 While rst_n = 0 at a clk edge: TX FSM = IDLE, counters = 0.
REQ-026 While rst_n = 0 at a clk edge: all phy_tx_* and rx_* = 0, tx_rdy = 0, RX phase = low.
REQ-027 While rst_n = 0 at a clk edge: spd = cfg_speed, stat_link = 0, stat_duplex = 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately; no partial byte is emitted afterwards.

Configuration
REQ-029 Macro RGMII_INBAND_STATUS_EN defined: on a qualified sample with phy_rx_val = 0 and phy_rx_err = 0, decode phy_rx_dat[0] as link, [2:1] as speed and [3] as duplex.
REQ-030 With RGMII_INBAND_STATUS_EN: a decoded value SHALL update the stat_* outputs only after two identical consecutive decodes, and stat_speed SHALL be the spd source.
REQ-031 Macro RGMII_INBAND_STATUS_EN undefined: stat_link = 1 and stat_duplex = 1 after reset, stat_speed = cfg_speed, spd source = cfg_speed, and no decode logic is present.

Verification
REQ-032 1000M, bytes 0x55, 0xD5 back-to-back -> phy_tx_dat = 0x55 then 0xD5, each one cycle after accept, tx_rdy held at 1.
REQ-033 100M, byte 0xA3 -> phy_tx_dat = 0x33 for 5 cycles, then 0xAA for 5 cycles; tx_rdy pulses on the 10th cycle; no further tx_val -> IDLE.
REQ-034 10M, cfg_speed changed to 1000M during the 2nd of 3 bytes -> all 3 bytes sent at 50 cycles/nibble, next frame at 1000M.
REQ-035 100M RX, ce every 5 cycles, nibbles 5,5,D,5 -> rx_val strobes with 0x55 then 0x5D; an odd 7th nibble 0x7 -> 0x07 with rx_err = 1.
REQ-036 rst_n low on cycle 3 of an HI hold -> next cycle all outputs 0, FSM IDLE, tx_rdy = 1 one cycle after rst_n rises.
REQ-037 RGMII_INBAND_STATUS_EN defined, idle samples 0xB twice (link 1, speed 01, duplex 1) -> stat_link = 1, stat_speed = 01, stat_duplex = 1; a single 0x0 sample -> no change.
